// File: rtl/pixel_fx_pkg.sv
// Shared types and helpers for the pixel effect pipeline:
// effect codes, default gain and RGB word pack/unpack.
package pixel_fx_pkg;

    typedef enum logic [2:0] {
        PASS   = 3'd0,
        INVERT = 3'd1,
        GREY   = 3'd2,
        GAIN   = 3'd3,
        THRESH = 3'd4
    } fx_mode_e;

    localparam int DEFAULT_GAIN = 1;
    localparam int MAX_CH_W     = 8;

    typedef logic [MAX_CH_W-1:0]   ch_t;
    typedef logic [3*MAX_CH_W-1:0] rgb_word_t;

    // sel: 2 = R (high), 1 = G, 0 = B (low)
    function automatic ch_t unpack_ch(
        input rgb_word_t   word,
        input int unsigned sel,
        input int unsigned cw
    );
        rgb_word_t mask;
        mask = (rgb_word_t'(1) << cw) - rgb_word_t'(1);
        return ch_t'((word >> (sel * cw)) & mask);
    endfunction

    function automatic rgb_word_t pack_rgb(
        input ch_t         r,
        input ch_t         g,
        input ch_t         b,
        input int unsigned cw
    );
        return (rgb_word_t'(r) << (2 * cw))
             | (rgb_word_t'(g) << cw)
             | rgb_word_t'(b);
    endfunction

endpackage

// File: rtl/palette_ram.sv
// Banked colour palette: one synchronous read port, one write port.
// No reset on the array so it maps onto block RAM.
module palette_ram #(
    parameter int NUM_SRC = 4,
    parameter int IDX_W   = 6,
    parameter int DW      = 12,
    localparam int SEL_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
    localparam int DEPTH  = NUM_SRC << IDX_W,
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rd_en,
    input  logic [SEL_W-1:0] rd_bank,
    input  logic [IDX_W-1:0] rd_addr,
    output logic [DW-1:0]    rd_data,
    input  logic             wr_en,
    input  logic [SEL_W-1:0] wr_bank,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [DW-1:0]    wr_data
);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] ra;
    logic [AW-1:0] wa;

    assign ra = (AW'(rd_bank) << IDX_W) + AW'(rd_addr);
    assign wa = (AW'(wr_bank) << IDX_W) + AW'(wr_addr);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wa] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[ra];
        end
    end

endmodule

// File: rtl/pixel_fx_pipeline.sv
// Pixel back-end: source select, palette lookup, per-frame effect.
// Config is captured at frame start and travels with each pixel.
module pixel_fx_pipeline
    import pixel_fx_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int IDX_W   = 6,
    parameter int CH_W    = 4,
    parameter int GAIN_W  = 4,
    localparam int SEL_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
    localparam int PW     = 3 * CH_W
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_pix_stb,
    input  logic                     i_active,
    input  logic                     i_frame_start,
    input  logic [NUM_SRC*IDX_W-1:0] i_idx,
    input  logic [SEL_W-1:0]         i_src_sel,
    input  logic [SEL_W-1:0]         i_pal_sel,
    input  logic [2:0]               i_mode,
    input  logic [GAIN_W-1:0]        i_gain,
    input  logic                     i_pal_wr_valid,
    output logic                     o_pal_wr_ready,
    input  logic [SEL_W-1:0]         i_pal_wr_bank,
    input  logic [IDX_W-1:0]         i_pal_wr_addr,
    input  logic [PW-1:0]            i_pal_wr_data,
    output logic [CH_W-1:0]          o_r,
    output logic [CH_W-1:0]          o_g,
    output logic [CH_W-1:0]          o_b,
    output logic                     o_active
);

    localparam int PG_W = CH_W + GAIN_W;
    localparam logic [CH_W-1:0] CH_MAX = '1;

    function automatic logic [SEL_W-1:0] clamp_sel(
        input logic [SEL_W-1:0] s
    );
        return (int'(s) < NUM_SRC) ? s : '0;
    endfunction

    function automatic logic [CH_W-1:0] fx_ch(
        input logic [2:0]        m,
        input logic [CH_W-1:0]   c,
        input logic [CH_W-1:0]   grey,
        input logic [GAIN_W-1:0] g
    );
        logic [PG_W-1:0] p;
        logic [CH_W-1:0] res;
        p   = PG_W'(c) * PG_W'(g);
        res = c;
        case (m)
            INVERT: res = CH_MAX - c;
            GREY:   res = grey;
            GAIN: begin
                if (g == '0)
                    res = c;
                else if (p > PG_W'(CH_MAX))
                    res = CH_MAX;
                else
                    res = p[CH_W-1:0];
            end
            THRESH: res = c[CH_W-1] ? CH_MAX : '0;
            default: res = c;
        endcase
        return res;
    endfunction

    logic              load;
    logic [SEL_W-1:0]  src_q, pal_q;
    logic [2:0]        mode_q;
    logic [GAIN_W-1:0] gain_q;
    logic [SEL_W-1:0]  src_eff, pal_eff;
    logic [2:0]        mode_eff;
    logic [GAIN_W-1:0] gain_eff;

    logic [IDX_W-1:0]  idx1;
    logic [SEL_W-1:0]  pal1;
    logic [2:0]        mode1, mode2;
    logic [GAIN_W-1:0] gain1, gain2;
    logic              act1, act2, act3;
    logic [PW-1:0]     rd_data;
    logic [PW-1:0]     rgb3;

    logic [CH_W-1:0]   r2, g2, b2, grey2;
    logic [CH_W+1:0]   sum2;
    logic              wr_en;

    assign load = i_pix_stb & i_frame_start;

    // The frame-start pixel itself must already see the new config.
    assign src_eff  = load ? clamp_sel(i_src_sel) : src_q;
    assign pal_eff  = load ? clamp_sel(i_pal_sel) : pal_q;
    assign mode_eff = load ? i_mode : mode_q;
    assign gain_eff = load ? i_gain : gain_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            src_q  <= '0;
            pal_q  <= '0;
            mode_q <= PASS;
            gain_q <= GAIN_W'(DEFAULT_GAIN);
        end else if (load) begin
            src_q  <= src_eff;
            pal_q  <= pal_eff;
            mode_q <= mode_eff;
            gain_q <= gain_eff;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            idx1  <= '0;
            pal1  <= '0;
            mode1 <= PASS;
            gain1 <= '0;
            act1  <= 1'b0;
            mode2 <= PASS;
            gain2 <= '0;
            act2  <= 1'b0;
            rgb3  <= '0;
            act3  <= 1'b0;
        end else if (i_pix_stb) begin
            idx1  <= i_idx[src_eff*IDX_W +: IDX_W];
            pal1  <= pal_eff;
            mode1 <= mode_eff;
            gain1 <= gain_eff;
            act1  <= i_active;
            mode2 <= mode1;
            gain2 <= gain1;
            act2  <= act1;
            act3  <= act2;
            rgb3  <= act2
                   ? PW'(pack_rgb(ch_t'(fx_ch(mode2, r2, grey2, gain2)),
                                  ch_t'(fx_ch(mode2, g2, grey2, gain2)),
                                  ch_t'(fx_ch(mode2, b2, grey2, gain2)),
                                  CH_W))
                   : '0;
        end
    end

    assign wr_en = i_pal_wr_valid & o_pal_wr_ready
                 & (int'(i_pal_wr_bank) < NUM_SRC);

    palette_ram #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W),
        .DW      (PW)
    ) u_palette (
        .clk     (i_clk),
        .rd_en   (i_pix_stb),
        .rd_bank (pal1),
        .rd_addr (idx1),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_bank (i_pal_wr_bank),
        .wr_addr (i_pal_wr_addr),
        .wr_data (i_pal_wr_data)
    );

    assign r2    = CH_W'(unpack_ch(rgb_word_t'(rd_data), 2, CH_W));
    assign g2    = CH_W'(unpack_ch(rgb_word_t'(rd_data), 1, CH_W));
    assign b2    = CH_W'(unpack_ch(rgb_word_t'(rd_data), 0, CH_W));
    assign sum2  = (CH_W+2)'(r2) + (CH_W+2)'(g2) + (CH_W+2)'(b2);
    assign grey2 = CH_W'(sum2 / (CH_W+2)'(3));

    assign o_pal_wr_ready = !(i_active | act1 | act2 | act3);

    assign o_r      = CH_W'(unpack_ch(rgb_word_t'(rgb3), 2, CH_W));
    assign o_g      = CH_W'(unpack_ch(rgb_word_t'(rgb3), 1, CH_W));
    assign o_b      = CH_W'(unpack_ch(rgb_word_t'(rgb3), 0, CH_W));
    assign o_active = act3;

endmodule

// File: tb/tb_pixel_fx_pipeline.sv
// Directed bench for pixel_fx_pipeline with default parameters.
// Strobe is issued once every 4 clocks; outputs sampled on negedge.
module tb_pixel_fx_pipeline;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pix_stb = 1'b0;
    logic        active = 1'b0;
    logic        frame_start = 1'b0;
    logic [23:0] idx = '0;
    logic [1:0]  src_sel = '0;
    logic [1:0]  pal_sel = '0;
    logic [2:0]  mode = '0;
    logic [3:0]  gain = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [1:0]  wr_bank = '0;
    logic [5:0]  wr_addr = '0;
    logic [11:0] wr_data = '0;
    logic [3:0]  r, g, b;
    logic        act_out;

    int errors = 0;
    int checks = 0;

    // source 2 = 5, source 0 = 9
    localparam logic [23:0] IDX_S2_5 = 24'h005009;
    // source 2 = 5, source 0 = 7
    localparam logic [23:0] IDX_S0_7 = 24'h005007;

    always #5 clk = ~clk;

    pixel_fx_pipeline dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_pix_stb      (pix_stb),
        .i_active       (active),
        .i_frame_start  (frame_start),
        .i_idx          (idx),
        .i_src_sel      (src_sel),
        .i_pal_sel      (pal_sel),
        .i_mode         (mode),
        .i_gain         (gain),
        .i_pal_wr_valid (wr_valid),
        .o_pal_wr_ready (wr_ready),
        .i_pal_wr_bank  (wr_bank),
        .i_pal_wr_addr  (wr_addr),
        .i_pal_wr_data  (wr_data),
        .o_r            (r),
        .o_g            (g),
        .o_b            (b),
        .o_active       (act_out)
    );

    task automatic pix(input logic a, input logic fs,
                       input logic [23:0] ix, input logic [2:0] m,
                       input logic [3:0] gn);
        @(negedge clk);
        active      = a;
        frame_start = fs;
        idx         = ix;
        mode        = m;
        gain        = gn;
        pix_stb     = 1'b1;
        @(negedge clk);
        pix_stb     = 1'b0;
        frame_start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic drain();
        repeat (3) pix(1'b0, 1'b0, idx, mode, gain);
    endtask

    task automatic pal_write(input logic [1:0] bk, input logic [5:0] ad,
                             input logic [11:0] dt);
        int n;
        @(negedge clk);
        wr_valid = 1'b1;
        wr_bank  = bk;
        wr_addr  = ad;
        wr_data  = dt;
        n = 0;
        while (!wr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL pal_write_ready: got %b want 1", wr_ready);
        end
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic run_frame(input logic [2:0] m, input logic [3:0] gn,
                             input logic [23:0] ix,
                             output logic [12:0] got);
        pix(1'b1, 1'b1, ix, m, gn);
        pix(1'b1, 1'b0, ix, m, gn);
        pix(1'b1, 1'b0, ix, m, gn);
        got = {act_out, r, g, b};
        drain();
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        active = 1'b1;
        #1;
        checks++;
        if ({act_out, r, g, b} !== 13'h0 || wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %h rdy %b want 0 rdy 0",
                     {act_out, r, g, b}, wr_ready);
        end
        active = 1'b0;
        #1;
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_idle: got %b want 1", wr_ready);
        end
        active = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            pix(1'b1, 1'b0, 24'h0, 3'd0, 4'd0);
            checks++;
            if (act_out !== (k == 3)) begin
                errors++;
                $display("FAIL reset_latency strobe %0d: got %b want %b",
                         k, act_out, (k == 3));
            end
        end
        checks++;
        if ({r, g, b} !== 12'h000) begin
            errors++;
            $display("FAIL reset_rgb: got %h want 000", {r, g, b});
        end
    endtask

    task automatic test_pass();
        logic [12:0] got;
        drain();
        pal_write(2'd1, 6'd5, 12'hA3C);
        pal_write(2'd1, 6'd6, 12'h2A1);
        pal_write(2'd0, 6'd7, 12'h4B2);
        src_sel = 2'd2;
        pal_sel = 2'd1;
        run_frame(3'd0, 4'd1, IDX_S2_5, got);
        checks++;
        if (got !== 13'h1A3C) begin
            errors++;
            $display("FAIL pass: got %h want 1a3c", got);
        end
    endtask

    task automatic test_effects();
        logic [12:0] got;
        logic [2:0]  modes [4] = '{3'd1, 3'd2, 3'd4, 3'd6};
        logic [12:0] exp   [4] = '{13'h15C3, 13'h1888, 13'h1F0F, 13'h1A3C};
        for (int i = 0; i < 4; i++) begin
            run_frame(modes[i], 4'd1, IDX_S2_5, got);
            checks++;
            if (got !== exp[i]) begin
                errors++;
                $display("FAIL effect mode %0d: got %h want %h",
                         modes[i], got, exp[i]);
            end
        end
    endtask

    task automatic test_gain();
        logic [12:0] got;
        logic [23:0] ix6;
        ix6 = 24'h006000;
        run_frame(3'd3, 4'd3, ix6, got);
        checks++;
        if (got !== 13'h16F3) begin
            errors++;
            $display("FAIL gain3: got %h want 16f3", got);
        end
        run_frame(3'd3, 4'd0, ix6, got);
        checks++;
        if (got !== 13'h12A1) begin
            errors++;
            $display("FAIL gain0: got %h want 12a1", got);
        end
    endtask

    task automatic test_midframe();
        logic [12:0] exp;
        for (int k = 0; k < 7; k++) begin
            pix(1'b1, (k == 0) || (k == 4), IDX_S2_5,
                (k == 0) ? 3'd0 : 3'd1, 4'd1);
            if (k >= 2) begin
                exp = (k == 6) ? 13'h15C3 : 13'h1A3C;
                checks++;
                if ({act_out, r, g, b} !== exp) begin
                    errors++;
                    $display("FAIL midframe pixel %0d: got %h want %h",
                             k - 2, {act_out, r, g, b}, exp);
                end
            end
        end
        drain();
    endtask

    task automatic test_write_during_active();
        logic [12:0] got;
        pix(1'b1, 1'b1, IDX_S2_5, 3'd0, 4'd1);
        @(negedge clk);
        wr_valid = 1'b1;
        wr_bank  = 2'd1;
        wr_addr  = 6'd5;
        wr_data  = 12'h123;
        for (int k = 0; k < 4; k++) begin
            pix(1'b1, 1'b0, IDX_S2_5, 3'd0, 4'd1);
            checks++;
            if (wr_ready !== 1'b0) begin
                errors++;
                $display("FAIL wr_active_ready %0d: got %b want 0",
                         k, wr_ready);
            end
        end
        checks++;
        if ({act_out, r, g, b} !== 13'h1A3C) begin
            errors++;
            $display("FAIL wr_active_unchanged: got %h want 1a3c",
                     {act_out, r, g, b});
        end
        for (int k = 1; k <= 3; k++) begin
            pix(1'b0, 1'b0, IDX_S2_5, 3'd0, 4'd1);
            checks++;
            if (wr_ready !== (k == 3)) begin
                errors++;
                $display("FAIL wr_drain_ready %0d: got %b want %b",
                         k, wr_ready, (k == 3));
            end
        end
        wr_valid = 1'b0;
        wr_data  = 12'hFFF;
        run_frame(3'd0, 4'd1, IDX_S2_5, got);
        checks++;
        if (got !== 13'h1123) begin
            errors++;
            $display("FAIL wr_readback: got %h want 1123", got);
        end
    endtask

    task automatic test_reset_midframe();
        pix(1'b1, 1'b1, IDX_S0_7, 3'd1, 4'd1);
        pix(1'b1, 1'b0, IDX_S0_7, 3'd1, 4'd1);
        pix(1'b1, 1'b0, IDX_S0_7, 3'd1, 4'd1);
        checks++;
        if ({act_out, r, g, b} !== 13'h1EDC) begin
            errors++;
            $display("FAIL rst_mid_before: got %h want 1edc",
                     {act_out, r, g, b});
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({act_out, r, g, b} !== 13'h0) begin
            errors++;
            $display("FAIL rst_mid_zero: got %h want 0", {act_out, r, g, b});
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) pix(1'b1, 1'b0, IDX_S0_7, 3'd1, 4'd9);
        checks++;
        if ({act_out, r, g, b} !== 13'h14B2) begin
            errors++;
            $display("FAIL rst_mid_defaults: got %h want 14b2",
                     {act_out, r, g, b});
        end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_effects();
        test_gain();
        test_midframe();
        test_write_during_active();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
